fetch_stage: RTL

//  Instruction-fetch stage: owns the fetch PC, issues req/ready reads to instruction memory, and loads the IF/ID register.

---
 rtl/arm_pipeline_pkg.sv | 14 +
 rtl/if_id_reg.sv | 52 +++++
 rtl/fetch_stage.sv | 126 ++++++++++++
 3 files changed

// File: rtl/arm_pipeline_pkg.sv
// Shared constants and fetch-state encodings for the pipeline front end.
package arm_pipeline_pkg;

  localparam int DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] PC_STEP      = 32'd4;
  localparam logic [DATA_WIDTH-1:0] BUBBLE_INSTR = 32'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: {pc, instr, valid}; flush wins over freeze, freeze wins over load.
module if_id_reg
  import arm_pipeline_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  flush_i,
  input  logic                  freeze_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic                  valid_o
);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush_i) begin
      pc_d    = '0;
      instr_d = BUBBLE_INSTR;
      valid_d = 1'b0;
    end else if (!freeze_i && load_i) begin
      pc_d    = pc_i;
      instr_d = instr_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      instr_q <= BUBBLE_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: fetch PC, req/ready memory reads, freeze hold buffer and branch redirect.
module fetch_stage
  import arm_pipeline_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_Freeze,
  input  logic                  i_Branch_Taken,
  input  logic [DATA_WIDTH-1:0] i_Branch_Addr,
  output logic                  o_Mem_Req,
  output logic [DATA_WIDTH-1:0] o_Mem_Addr,
  input  logic                  i_Mem_Ready,
  input  logic [DATA_WIDTH-1:0] i_Mem_Data,
  output logic [DATA_WIDTH-1:0] o_PC,
  output logic [DATA_WIDTH-1:0] o_Instruction,
  output logic                  o_Valid
);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] redirect_q, redirect_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  discard_q, discard_d;

  logic                  hs;
  logic                  ifid_load, ifid_flush;
  logic [DATA_WIDTH-1:0] ifid_pc, ifid_instr;

  assign hs = (state_q == S_REQ) && i_Mem_Ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = redirect_q;
    hold_d     = hold_q;
    discard_d  = discard_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_pc    = pc_q + PC_STEP;
    ifid_instr = i_Mem_Data;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (i_Branch_Taken) begin
          pc_d       = i_Branch_Addr;
          ifid_flush = 1'b1;
        end
      end
      S_REQ: begin
        if (i_Branch_Taken) begin
          ifid_flush = 1'b1;
          if (hs) begin
            pc_d      = i_Branch_Addr;
            discard_d = 1'b0;
          end else begin
            // Address must stay stable until the outstanding read completes.
            redirect_d = i_Branch_Addr;
            discard_d  = 1'b1;
          end
        end else if (hs && discard_q) begin
          pc_d       = redirect_q;
          discard_d  = 1'b0;
          ifid_flush = 1'b1;
        end else if (hs) begin
          pc_d = pc_q + PC_STEP;
          if (i_Freeze) begin
            hold_d  = i_Mem_Data;
            state_d = S_HOLD;
          end else begin
            ifid_load = 1'b1;
          end
        end else if (!i_Freeze) begin
          ifid_flush = 1'b1;
        end
      end
      S_HOLD: begin
        if (i_Branch_Taken) begin
          pc_d       = i_Branch_Addr;
          hold_d     = BUBBLE_INSTR;
          ifid_flush = 1'b1;
          state_d    = S_REQ;
        end else if (!i_Freeze) begin
          // pc_q already advanced past the held word, so it is that word's PC+step.
          ifid_load  = 1'b1;
          ifid_pc    = pc_q;
          ifid_instr = hold_q;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      redirect_q <= '0;
      hold_q     <= BUBBLE_INSTR;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      hold_q     <= hold_d;
      discard_q  <= discard_d;
    end
  end

  assign o_Mem_Req  = (state_q == S_REQ);
  assign o_Mem_Addr = pc_q;

  if_id_reg u_if_id (
    .clk      (clk),
    .rst_n    (reset),
    .load_i   (ifid_load),
    .flush_i  (ifid_flush),
    .freeze_i (i_Freeze),
    .pc_i     (ifid_pc),
    .instr_i  (ifid_instr),
    .pc_o     (o_PC),
    .instr_o  (o_Instruction),
    .valid_o  (o_Valid)
  );

endmodule
